hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage RISC-V core. It drives the per-stage hold (enable) and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It resolves three conditions: load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory accesses. A wait-timeout FSM halts the pipeline on a hung memory, and free-running counters record stall and flush activity.

---
 rtl/hazard_ctrl_pkg.sv | 14 +
 rtl/hazard_detect.sv | 18 +
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: register index width, x0 and the
// sequencing FSM state encoding.
package hazard_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam logic [REG_W-1:0] X0 = 5'd0;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StHalt    = 2'd2
   } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the instruction in ID
// reads. Writes to x0 never create a dependency.
module hazard_detect
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   output logic             load_use
);

   // Pure combinational match
   always_comb begin
      load_use = ex_mem_read && (ex_rd != X0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-stage hold/flush generation, dmem wait
// timeout FSM and stall/flush activity counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 16,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             mem_branch,
   input  logic             mem_comp,
   input  logic             mem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic             pc_src,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WaitW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   // Counter value during the last permitted not-ready MEM_WAIT cycle
   localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_MAX - 1);

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic load_use;
   logic branch_taken;
   logic mem_stall;

   hazard_detect u_hazard_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .load_use    (load_use)
   );

   assign branch_taken = mem_branch & mem_comp;
   assign mem_stall    = mem_req & ~dmem_ready;

   // Stage controls: mem_stall > branch_taken > load_use > normal; HALT freezes all
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      pc_src       = 1'b0;
      if (state_q == StHalt) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
      end else if (mem_stall) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         // Bubble into WB so the stalled MEM instruction does not retire twice
         mem_wb_flush = 1'b1;
      end else if (branch_taken) begin
         // Squash the three younger instructions, including any load-use victim
         pc_src       = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   // FSM next state and wait counter
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         StRun: begin
            wait_cnt_d = '0;
            if (mem_stall) state_d = StMemWait;
         end
         StMemWait: begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
            if (dmem_ready) begin
               state_d = StRun;
            end else if (wait_cnt_q == WaitLast) begin
               state_d = StHalt;
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d    = StRun;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Performance counters, free-running and wrapping
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((state_q != StHalt) && !pc_en) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (pc_src) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StRun;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign halted    = (state_q == StHalt);
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then biased random traffic,
// checked against a cycle-level behavioural model of the sequencing rules.
module tb_hazard_ctrl;

   localparam int unsigned WaitMax = 16;
   localparam int unsigned CntW    = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [4:0]      id_rs1, id_rs2, ex_rd;
   logic            ex_mem_read, mem_branch, mem_comp, mem_req, dmem_ready;
   logic            pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic            pc_src, halted;
   logic [CntW-1:0] stall_cnt, flush_cnt;

   hazard_ctrl #(
      .WAIT_MAX (WaitMax),
      .CNT_W    (CntW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .ex_mem_read  (ex_mem_read),
      .ex_rd        (ex_rd),
      .mem_branch   (mem_branch),
      .mem_comp     (mem_comp),
      .mem_req      (mem_req),
      .dmem_ready   (dmem_ready),
      .pc_en        (pc_en),
      .if_id_en     (if_id_en),
      .id_ex_en     (id_ex_en),
      .ex_mem_en    (ex_mem_en),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .ex_mem_flush (ex_mem_flush),
      .mem_wb_flush (mem_wb_flush),
      .pc_src       (pc_src),
      .halted       (halted),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   always #5 clk = ~clk;

   // ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, pc_src}
   typedef struct {
      logic [8:0] ctl;
      logic       halted;
      int         scnt;
      int         fcnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: mode 0 = running, 1 = waiting on memory, 2 = halted
   int m_mode, m_waited, m_scnt, m_fcnt;

   task automatic step(input logic rst, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                       input logic cmp, input logic req, input logic rdy);
      exp_t e;
      bit   ms, bt, lu;
      @(posedge clk);
      #1;
      reset       = rst;
      ex_mem_read = mr;
      ex_rd       = rd;
      id_rs1      = rs1;
      id_rs2      = rs2;
      mem_branch  = br;
      mem_comp    = cmp;
      mem_req     = req;
      dmem_ready  = rdy;
      ms = req && !rdy;
      bt = br && cmp;
      lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
      e.halted = (m_mode == 2);
      e.scnt   = m_scnt;
      e.fcnt   = m_fcnt;
      if (m_mode == 2)  e.ctl = 9'b0000_0000_0;
      else if (ms)      e.ctl = 9'b0000_0001_0;
      else if (bt)      e.ctl = 9'b1111_1110_1;
      else if (lu)      e.ctl = 9'b0011_0100_0;
      else              e.ctl = 9'b1111_0000_0;
      exp_q.push_back(e);
      if (rst) begin
         m_mode = 0; m_waited = 0; m_scnt = 0; m_fcnt = 0;
      end else begin
         if (m_mode != 2 && e.ctl[8] == 1'b0) m_scnt = (m_scnt + 1) % (1 << CntW);
         if (e.ctl[0]) m_fcnt = (m_fcnt + 1) % (1 << CntW);
         if (m_mode == 0) begin
            if (ms) begin
               m_mode = 1;
               m_waited = 0;
            end
         end else if (m_mode == 1) begin
            if (rdy) m_mode = 0;
            else if (m_waited + 1 == WaitMax) m_mode = 2;
            else m_waited++;
         end
      end
   endtask

   // Monitor: outputs are presented every cycle; compare mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [8:0] act;
         e   = exp_q.pop_front();
         act = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
                ex_mem_flush, mem_wb_flush, pc_src};
         n_tests++;
         if (act !== e.ctl) begin
            n_fail++;
            $display("FAIL ctl @%0t: got %b expected %b", $time, act, e.ctl);
         end
         n_tests++;
         if (halted !== e.halted) begin
            n_fail++;
            $display("FAIL halted @%0t: got %b expected %b", $time, halted, e.halted);
         end
         n_tests++;
         if (stall_cnt !== CntW'(e.scnt)) begin
            n_fail++;
            $display("FAIL stall_cnt @%0t: got %0d expected %0d", $time, stall_cnt, e.scnt);
         end
         n_tests++;
         if (flush_cnt !== CntW'(e.fcnt)) begin
            n_fail++;
            $display("FAIL flush_cnt @%0t: got %0d expected %0d", $time, flush_cnt, e.fcnt);
         end
      end
   end

   initial begin
      int rdy_pct;
      reset = 1'b1;
      {ex_mem_read, mem_branch, mem_comp, mem_req, dmem_ready} = '0;
      {id_rs1, id_rs2, ex_rd} = '0;
      repeat (2) @(posedge clk);
      m_mode = 0; m_waited = 0; m_scnt = 0; m_fcnt = 0;

      // Reset state, then load-use on rs2
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 5, 1, 5, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // x0 destination never stalls
      step(0, 1, 0, 0, 3, 0, 0, 0, 0);
      // Branch taken overrides a concurrent load-use; not-taken is normal
      step(0, 1, 7, 7, 2, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0);
      // First-cycle ready: no stall
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      // Three not-ready cycles then ready
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Timeout into HALT, outputs frozen, reset recovers
      repeat (WaitMax + 4) step(0, 1, 3, 3, 0, 1, 1, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Ready on the 16th wait cycle returns to RUN instead of halting
      repeat (WaitMax) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Reset during MEM_WAIT with request still pending
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);

      // Random traffic; alternate blocks favour slow memory to reach timeouts
      for (int blk = 0; blk < 8; blk++) begin
         rdy_pct = (blk % 2 == 0) ? 60 : 6;
         for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2),
                 $urandom_range(0, 1),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 30),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 99) < rdy_pct));
         end
      end

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
